// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM and the copy engine that drives it.
// Default geometry matches the team's dpram instance.
package dpram_pkg;

    localparam int DPRAM_DATA_WIDTH = 8;
    localparam int DPRAM_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

endpackage

// File: rtl/dpram_copy_engine.sv
// Block copy inside one dpram: one read and one write per cycle, with memmove
// direction choice, XOR checksum of the moved words, and early abort.
module dpram_copy_engine
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output copy_state_t           dbg_state
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_LEN   = (ADDR_WIDTH+1)'(1);

    copy_state_t           state_q, state_d;
    logic                  desc_q, desc_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    logic [ADDR_WIDTH:0]   len_eff;
    logic [ADDR_WIDTH-1:0] last_off;
    logic [ADDR_WIDTH-1:0] step;

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        aborted_d  = aborted_q;
        checksum_d = checksum_q;
        len_eff    = (len > DEPTH_LEN) ? DEPTH_LEN : len;
        last_off   = ADDR_WIDTH'(len_eff - ONE_LEN);
        step       = desc_q ? '1 : ADDR_WIDTH'(1);

        // Write stage: the word read last cycle lands now; advance the write pointer.
        if (wr_en_q) begin
            checksum_d = checksum_q ^ data_out;
            wr_addr_d  = wr_addr_q + step;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    desc_d     = dst_addr > src_addr;
                    cnt_d      = len_eff;
                    aborted_d  = 1'b0;
                    checksum_d = '0;
                    rd_addr_d  = (dst_addr > src_addr) ? src_addr + last_off : src_addr;
                    wr_addr_d  = (dst_addr > src_addr) ? dst_addr + last_off : dst_addr;
                    // An empty copy still spends one busy cycle so done lands in cycle 2.
                    state_d    = (len_eff == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                rd_addr_d = rd_addr_q + step;
                cnt_d     = cnt_q - ONE_LEN;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else if (cnt_q == ONE_LEN) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_en_d = (state_d == RUN);
        wr_en_d = rd_en_q;
        busy_d  = (state_d == RUN) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            desc_q     <= 1'b0;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            checksum_q <= checksum_d;
        end
    end

    // The RAM's registered read port feeds the write port directly; gating on
    // wr_en keeps data_in at zero whenever no write is in flight.
    assign data_in   = wr_en_q ? data_out : '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign checksum  = checksum_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dpram_copy_engine.sv
// Directed bench for dpram_copy_engine with a behavioural dpram, a write
// scoreboard, and a reference image of the RAM.
module tb_dpram_copy_engine;
    import dpram_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [DW-1:0] checksum;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    copy_state_t   dbg_state;

    dpram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .checksum  (checksum),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .dbg_state (dbg_state)
    );

    // behavioural dpram plus a bulk-load path from the reference image
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          load_all = 1'b0;

    always @(posedge clk) begin
        if (load_all) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
        end else if (wr_en) begin
            ram[wr_addr] <= data_in;
        end
        if (rd_en) data_out <= ram[rd_addr];
    end

    // scoreboard
    logic [AW+DW-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [DW-1:0]    prev_cs = '0;
    logic             prev_ab = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {1'b0, busy, done, aborted, rd_en, wr_en, rd_addr, wr_addr,
                data_in, checksum, 2'(dbg_state)};
    endfunction

    task automatic sync_ram();
        @(negedge clk);
        load_all = 1'b1;
        @(negedge clk);
        load_all = 1'b0;
    endtask

    task automatic check_ram(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) diffs++;
        check(tag, diffs, 0);
    endtask

    // One copy, cycle by cycle. abort_k / rst_k / busy_k: cycle in which abort,
    // reset or a stray start is applied (0 = never).
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l,
                            input int abort_k, input int rst_k, input int busy_k);
        int               n, nw, last_rd, done_c, end_c, off;
        logic             desc, alive;
        logic [DW-1:0]    snap [DEPTH];
        logic [DW-1:0]    exp_cs;
        logic [AW-1:0]    a_src, a_dst;
        logic [AW+DW-1:0] e;

        n       = (int'(l) > DEPTH) ? DEPTH : int'(l);
        desc    = d > s;
        last_rd = (abort_k > 0) ? abort_k : n;
        nw      = (rst_k > 0) ? rst_k - 1 : last_rd;
        done_c  = (n == 0) ? 2 : last_rd + 2;
        end_c   = (rst_k > 0) ? rst_k + 2 : done_c;
        snap    = ref_mem;
        exp_cs  = '0;
        for (int j = 0; j < nw; j++) begin
            off   = desc ? n - 1 - j : j;
            a_src = s + AW'(off);
            a_dst = d + AW'(off);
            exp_q.push_back({a_dst, snap[a_src]});
            ref_mem[a_dst] = snap[a_src];
            exp_cs ^= snap[a_src];
        end

        @(negedge clk);
        check("checksum_hold", checksum, prev_cs);
        check("aborted_hold", aborted, prev_ab);
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            start = (c == busy_k);
            if (c == busy_k) begin
                src_addr = AW'($urandom_range(0, DEPTH - 1));
                dst_addr = AW'($urandom_range(0, DEPTH - 1));
                len      = 5'd9;
            end
            abort = (c == abort_k);
            reset = !(c == rst_k);
            alive = (rst_k == 0) || (c <= rst_k);
            check("rd_en", rd_en, alive && c <= last_rd);
            check("wr_en", wr_en, alive && c >= 2 && c <= last_rd + 1);
            check("busy", busy, alive && c <= done_c - 1);
            check("done", done, alive && c == done_c);
            if (wr_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_word", {wr_addr, data_in}, e);
            end
            if (alive && c == done_c) begin
                check("checksum", checksum, exp_cs);
                check("aborted", aborted, abort_k > 0);
            end
            if (rst_k > 0 && c == rst_k + 1) check("reset_zero", all_outputs(), 0);
        end
        start = 1'b0; abort = 1'b0; reset = 1'b1;
        check("wr_pending", exp_q.size(), 0);
        exp_q.delete();
        check_ram("ram_image");
        prev_cs = (rst_k > 0) ? '0 : exp_cs;
        prev_ab = (rst_k == 0) && (abort_k > 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom_range(0, 255));
        repeat (3) @(negedge clk);
        check("reset_state", all_outputs(), 0);
        reset = 1'b1;

        // plain copy, 4 words
        ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33; ref_mem[3] = 8'h44;
        sync_ram();
        run_copy(4'd0, 4'd8, 5'd4, 0, 0, 0);
        check("cs_const", checksum, 8'h44);
        check("copy_8", ram[8], 8'h11);
        check("copy_11", ram[11], 8'h44);

        // overlap, destination above source
        ref_mem[2] = 8'hA1; ref_mem[3] = 8'hA2; ref_mem[4] = 8'hA3; ref_mem[5] = 8'hA4;
        sync_ram();
        run_copy(4'd2, 4'd3, 5'd4, 0, 0, 0);
        check("fwd_2", ram[2], 8'hA1);
        check("fwd_3", ram[3], 8'hA1);
        check("fwd_6", ram[6], 8'hA4);

        // overlap, destination below source
        ref_mem[5] = 8'hB1; ref_mem[6] = 8'hB2; ref_mem[7] = 8'hB3;
        sync_ram();
        run_copy(4'd5, 4'd4, 5'd3, 0, 0, 0);
        check("bwd_4", ram[4], 8'hB1);
        check("bwd_6", ram[6], 8'hB3);

        // source wraps past the top of the RAM
        ref_mem[14] = 8'hC1; ref_mem[15] = 8'hC2; ref_mem[0] = 8'hC3;
        sync_ram();
        run_copy(4'd14, 4'd6, 5'd3, 0, 0, 0);
        check("wrap_6", ram[6], 8'hC1);
        check("wrap_8", ram[8], 8'hC3);

        // len beyond DEPTH clamps to 16 words
        run_copy(4'd0, 4'd0, 5'd20, 0, 0, 0);

        // abort in cycle 2 of a len-8 copy, stray start while busy in cycle 3
        run_copy(4'd0, 4'd8, 5'd8, 2, 0, 3);

        // reset in cycle 3 of a len-6 copy
        run_copy(4'd1, 4'd9, 5'd6, 0, 3, 0);

        // fresh copy, then an empty copy back to back
        run_copy(4'd4, 4'd10, 5'd5, 0, 0, 0);
        run_copy(4'd3, 4'd5, 5'd0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
